pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for the Pong display on the 6-bit character grid.
- Owns ball position, motion and scoring, detects collisions against the two paddle blocks, and gates paddle movement.
- Produces the registered ball pixel strobe for the VGA pixel mux, alongside the paddle draw strobes.

Parameters:
BALL_SPEED, 2500000, clocks per ball movement tick
SERVE_TICKS, 8, ball ticks spent in SERVE before play starts
WIN_SCORE, 5, score that ends the game (max 15)
LEFT_X, 2, left paddle column; paddle occupies LEFT_X..LEFT_X+1
RIGHT_X, 37, right paddle column; paddle occupies RIGHT_X..RIGHT_X+1
TOP_Y, 6, top wall row (ball may occupy)
BOTTOM_Y, 28, bottom wall row (ball may occupy)
X_MAX, 39, rightmost playfield column; leftmost is 0
CENTER_X, 20, serve column
CENTER_Y, 17, serve row

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
btn_start  in  1  start/restart button, level
paddle_l_y  in  6  left paddle top row; paddle spans paddle_l_y..paddle_l_y+6
paddle_r_y  in  6  right paddle top row; same span rule
counter_x  in  6  current pixel-cell column
counter_y  in  6  current pixel-cell row
ball_x  out  6  ball column
ball_y  out  6  ball row
draw_ball  out  1  registered ball pixel strobe
score_l  out  4  left player score
score_r  out  4  right player score
state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
paddle_en  out  1  paddles may move
game_over  out  1  high in OVER

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- rst (including mid-game), effective on the next edge:
  - state=IDLE, ball=(CENTER_X,CENTER_Y), dx=+1, dy=+1
  - scores=0, tick counter=0, serve counter=0
  - draw_ball=0, game_over=0, paddle_en=0, start_q=0
- Tick counter:
  - Free-runs 0..BALL_SPEED-1 and wraps.
  - tick is high for the one cycle the count equals BALL_SPEED-1.
- start_pulse = btn_start & ~start_q, where start_q is btn_start registered. A held button gives one pulse.
- IDLE: ball held at centre. start_pulse -> SERVE; scores cleared; serve counter cleared.
- SERVE: ball held at centre. Serve counter increments on each tick. When the count reaches SERVE_TICKS -> PLAY and the counter clears.
- PLAY: on each tick, update x and y independently in the same cycle (a corner hit flips both).
  - Y wall: if (dy=-1 and ball_y=TOP_Y) or (dy=+1 and ball_y=BOTTOM_Y), negate dy and move 1 row in the new direction; otherwise ball_y += dy.
  - Left hit: dx=-1, ball_x=LEFT_X+2, and paddle_l_y <= ball_y <= paddle_l_y+6 -> dx=+1, ball_x=LEFT_X+3.
  - Right hit: dx=+1, ball_x=RIGHT_X-1, and ball_y within the right span -> dx=-1, ball_x=RIGHT_X-2.
  - Left miss: dx=-1 and ball_x=0 -> score_r+1, go to POINT; ball_x does not move this tick.
  - Right miss: dx=+1 and ball_x=X_MAX -> score_l+1, go to POINT.
  - Otherwise ball_x += dx.
  - A missed ball keeps travelling behind the paddle column until it reaches the edge.
  - Span compare uses 7-bit arithmetic, so paddle_y+6 cannot wrap.
- POINT (one cycle):
  - If the new score equals WIN_SCORE -> OVER.
  - Otherwise ball recentres, dx points toward the player who conceded, dy is kept -> SERVE.
- OVER: game_over=1; ball frozen and not drawn. start_pulse -> SERVE, scores cleared, ball centred, dx=+1.
- paddle_en=1 in SERVE and PLAY only; it is a registered output decoded from the next state.
- draw_ball: registered; 1 cycle after counter_x==ball_x and counter_y==ball_y, in SERVE, PLAY or POINT.
- start_pulse outside IDLE/OVER is ignored.
- Scores saturate at 15; this cannot occur while WIN_SCORE<=15.

Test Plan:
1. Reset, then BALL_SPEED=4, SERVE_TICKS=2, pulse btn_start -> state 1 for 8 clocks, then 2; ball moves to (21,18) on the first tick.
2. Top wall: ball (10,6), dy=-1, dx=+1, tick -> ball (11,7), dy=+1. Same at BOTTOM_Y=28 -> row 27, dy=-1.
3. Left hit: paddle_l_y=10, ball (4,16) with dx=-1 -> (5,·), dx=+1. Repeat with ball_y=17 -> miss; ball continues to x=0, next tick score_r=1, POINT, then SERVE at (20,17) with dx=-1.
4. Corner: ball (36,6), dx=+1, dy=-1, paddle_r_y=6 -> ball (35,7), dx=-1, dy=+1 on the same tick.
5. WIN_SCORE=2: force two right misses -> score_l=2, state 4, game_over=1, draw_ball stays 0. Hold btn_start -> exactly one restart, scores 0.
6. rst asserted mid-PLAY with score_l=1 -> next edge: state 0, ball (20,17), scores 0, draw_ball 0, paddle_en 0.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, paddle collisions, scoring and the
// registered ball pixel strobe for the character-grid display.
module pong_game_ctrl #(
  parameter int BALL_SPEED  = 2500000,
  parameter int SERVE_TICKS = 8,
  parameter int WIN_SCORE   = 5,
  parameter int LEFT_X      = 2,
  parameter int RIGHT_X     = 37,
  parameter int TOP_Y       = 6,
  parameter int BOTTOM_Y    = 28,
  parameter int X_MAX       = 39,
  parameter int CENTER_X    = 20,
  parameter int CENTER_Y    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic [5:0] paddle_l_y,
  input  logic [5:0] paddle_r_y,
  input  logic [5:0] counter_x,
  input  logic [5:0] counter_y,
  output logic [5:0] ball_x,
  output logic [5:0] ball_y,
  output logic       draw_ball,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       paddle_en,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int TW = (BALL_SPEED > 1) ? $clog2(BALL_SPEED) : 1;
  localparam int SW = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(BALL_SPEED - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [5:0]    X_CENTER   = 6'(CENTER_X);
  localparam logic [5:0]    Y_CENTER   = 6'(CENTER_Y);
  localparam logic [5:0]    L_HIT      = 6'(LEFT_X + 2);
  localparam logic [5:0]    L_BOUNCE   = 6'(LEFT_X + 3);
  localparam logic [5:0]    R_HIT      = 6'(RIGHT_X - 1);
  localparam logic [5:0]    R_BOUNCE   = 6'(RIGHT_X - 2);
  localparam logic [5:0]    X_EDGE     = 6'(X_MAX);
  localparam logic [5:0]    Y_TOP      = 6'(TOP_Y);
  localparam logic [5:0]    Y_BOT      = 6'(BOTTOM_Y);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_cnt_reg;
  logic [SW-1:0] serve_cnt_reg;
  logic [5:0]    ball_x_reg, ball_y_reg;
  logic          dx_reg, dy_reg;  // 1 = moving toward larger coordinate
  logic [3:0]    score_l_reg, score_r_reg;
  logic          start_q_reg, draw_ball_reg, paddle_en_reg, game_over_reg;

  logic tick, start_pulse, serve_done, win;
  logic hit_l, hit_r, miss_l, miss_r;

  // 7-bit compare so a paddle near row 63 does not wrap its span.
  function automatic logic in_span(input logic [5:0] top, input logic [5:0] y);
    return ({1'b0, y} >= {1'b0, top}) && ({1'b0, y} <= ({1'b0, top} + 7'd6));
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hf) ? s : s + 4'd1;
  endfunction

  assign tick        = (tick_cnt_reg == TICK_LAST);
  assign start_pulse = btn_start & ~start_q_reg;
  assign serve_done  = tick && (serve_cnt_reg == SERVE_LAST);
  assign win         = (score_l_reg == WIN) || (score_r_reg == WIN);
  assign hit_l       = !dx_reg && (ball_x_reg == L_HIT) && in_span(paddle_l_y, ball_y_reg);
  assign hit_r       = dx_reg && (ball_x_reg == R_HIT) && in_span(paddle_r_y, ball_y_reg);
  assign miss_l      = !dx_reg && (ball_x_reg == 6'd0);
  assign miss_r      = dx_reg && (ball_x_reg == X_EDGE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_pulse) state_next = S_SERVE;
      S_SERVE: if (serve_done) state_next = S_PLAY;
      S_PLAY:  if (tick && !hit_l && !hit_r && (miss_l || miss_r)) state_next = S_POINT;
      S_POINT: state_next = win ? S_OVER : S_SERVE;
      S_OVER:  if (start_pulse) state_next = S_SERVE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      tick_cnt_reg  <= '0;
      serve_cnt_reg <= '0;
      ball_x_reg    <= X_CENTER;
      ball_y_reg    <= Y_CENTER;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      score_l_reg   <= 4'd0;
      score_r_reg   <= 4'd0;
      start_q_reg   <= 1'b0;
      draw_ball_reg <= 1'b0;
      paddle_en_reg <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      start_q_reg   <= btn_start;
      tick_cnt_reg  <= tick ? '0 : tick_cnt_reg + TW'(1);
      paddle_en_reg <= (state_next == S_SERVE) || (state_next == S_PLAY);
      game_over_reg <= (state_next == S_OVER);
      draw_ball_reg <= (counter_x == ball_x_reg) && (counter_y == ball_y_reg) &&
                       ((state_reg == S_SERVE) || (state_reg == S_PLAY) || (state_reg == S_POINT));
      case (state_reg)
        S_IDLE: begin
          ball_x_reg <= X_CENTER;
          ball_y_reg <= Y_CENTER;
          if (start_pulse) begin
            score_l_reg   <= 4'd0;
            score_r_reg   <= 4'd0;
            serve_cnt_reg <= '0;
          end
        end
        S_SERVE: begin
          ball_x_reg <= X_CENTER;
          ball_y_reg <= Y_CENTER;
          if (tick) serve_cnt_reg <= serve_done ? '0 : serve_cnt_reg + SW'(1);
        end
        S_PLAY: begin
          if (tick) begin
            if (!dy_reg && ball_y_reg == Y_TOP) begin
              dy_reg     <= 1'b1;
              ball_y_reg <= ball_y_reg + 6'd1;
            end else if (dy_reg && ball_y_reg == Y_BOT) begin
              dy_reg     <= 1'b0;
              ball_y_reg <= ball_y_reg - 6'd1;
            end else begin
              ball_y_reg <= dy_reg ? ball_y_reg + 6'd1 : ball_y_reg - 6'd1;
            end
            // A missed ball stays on the edge column for the POINT cycle.
            if (hit_l) begin
              dx_reg     <= 1'b1;
              ball_x_reg <= L_BOUNCE;
            end else if (hit_r) begin
              dx_reg     <= 1'b0;
              ball_x_reg <= R_BOUNCE;
            end else if (miss_l) begin
              score_r_reg <= sat_inc(score_r_reg);
            end else if (miss_r) begin
              score_l_reg <= sat_inc(score_l_reg);
            end else begin
              ball_x_reg <= dx_reg ? ball_x_reg + 6'd1 : ball_x_reg - 6'd1;
            end
          end
        end
        S_POINT: begin
          // dx still points at the player who conceded, which is the serve direction.
          if (!win) begin
            ball_x_reg    <= X_CENTER;
            ball_y_reg    <= Y_CENTER;
            serve_cnt_reg <= '0;
          end
        end
        S_OVER: begin
          if (start_pulse) begin
            score_l_reg   <= 4'd0;
            score_r_reg   <= 4'd0;
            ball_x_reg    <= X_CENTER;
            ball_y_reg    <= Y_CENTER;
            dx_reg        <= 1'b1;
            serve_cnt_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign draw_ball = draw_ball_reg;
  assign score_l   = score_l_reg;
  assign score_r   = score_r_reg;
  assign state     = state_reg;
  assign paddle_en = paddle_en_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios, a draw/timing vector table and
// randomized play, all checked each cycle against an integer game model.
module tb_pong_game_ctrl;

  localparam int BS = 4;
  localparam int ST = 2;
  localparam int WS = 2;
  localparam int LX = 2;
  localparam int RX = 37;
  localparam int TY = 6;
  localparam int BY = 28;
  localparam int XM = 39;
  localparam int CX = 20;
  localparam int CY = 17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic [5:0] paddle_l_y = 6'd0;
  logic [5:0] paddle_r_y = 6'd0;
  logic [5:0] counter_x = 6'd0;
  logic [5:0] counter_y = 6'd0;
  logic [5:0] ball_x, ball_y;
  logic       draw_ball, paddle_en, game_over;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .BALL_SPEED(BS), .SERVE_TICKS(ST), .WIN_SCORE(WS), .LEFT_X(LX), .RIGHT_X(RX),
    .TOP_Y(TY), .BOTTOM_Y(BY), .X_MAX(XM), .CENTER_X(CX), .CENTER_Y(CY)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .counter_x(counter_x), .counter_y(counter_y),
    .ball_x(ball_x), .ball_y(ball_y), .draw_ball(draw_ball),
    .score_l(score_l), .score_r(score_r), .state(state),
    .paddle_en(paddle_en), .game_over(game_over)
  );

  int n_vec = 0;
  int n_err = 0;

  // Game model: plain integers, directions as +1/-1, state numbers as on the port.
  int m_state, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_tick, m_serve;
  int m_startq, m_draw, m_pen, m_over;

  // Paddle stimulus modes: 0 follow ball, 1 parked out of reach, 2 random.
  int l_mode = 0;
  int r_mode = 0;
  int cx_set = 0;
  int cy_set = 0;

  typedef struct {
    int cx;
    int cy;
    int exp_draw;
    int exp_state;
  } vec_t;
  vec_t tbl[8];

  function automatic int pad_pos(input int mode);
    if (mode == 0) return (m_by >= 3) ? m_by - 3 : 0;
    if (mode == 1) return 50;
    return int'($urandom_range(0, 63));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int nst, nbx, nby, ndx, ndy, nsl, nsr, nserve, ny, pl, pr;
    bit tk, sp;
    if (rst) begin
      m_state = 0; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
      m_sl = 0; m_sr = 0; m_tick = 0; m_serve = 0;
      m_startq = 0; m_draw = 0; m_pen = 0; m_over = 0;
      return;
    end
    pl = int'(paddle_l_y);
    pr = int'(paddle_r_y);
    tk = (m_tick == BS - 1);
    sp = btn_start && (m_startq == 0);
    nst = m_state; nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy;
    nsl = m_sl; nsr = m_sr; nserve = m_serve;
    m_draw = (int'(counter_x) == m_bx && int'(counter_y) == m_by &&
              m_state >= 1 && m_state <= 3) ? 1 : 0;
    case (m_state)
      0: begin
        nbx = CX; nby = CY;
        if (sp) begin nst = 1; nsl = 0; nsr = 0; nserve = 0; end
      end
      1: begin
        nbx = CX; nby = CY;
        if (tk) begin
          nserve = m_serve + 1;
          if (nserve == ST) begin nserve = 0; nst = 2; end
        end
      end
      2: if (tk) begin
        ny = m_by + m_dy;
        if (ny < TY || ny > BY) begin ndy = -m_dy; ny = m_by + ndy; end
        nby = ny;
        if (m_dx < 0 && m_bx == LX + 2 && m_by >= pl && m_by <= pl + 6) begin
          ndx = 1; nbx = LX + 3;
        end else if (m_dx > 0 && m_bx == RX - 1 && m_by >= pr && m_by <= pr + 6) begin
          ndx = -1; nbx = RX - 2;
        end else if (m_bx + m_dx < 0) begin
          nsr = (m_sr < 15) ? m_sr + 1 : 15; nst = 3;
        end else if (m_bx + m_dx > XM) begin
          nsl = (m_sl < 15) ? m_sl + 1 : 15; nst = 3;
        end else begin
          nbx = m_bx + m_dx;
        end
      end
      3: begin
        if (m_sl == WS || m_sr == WS) nst = 4;
        else begin nst = 1; nbx = CX; nby = CY; nserve = 0; end
      end
      4: if (sp) begin
        nst = 1; nsl = 0; nsr = 0; nbx = CX; nby = CY; ndx = 1; nserve = 0;
      end
      default: nst = 0;
    endcase
    m_tick   = tk ? 0 : m_tick + 1;
    m_startq = btn_start ? 1 : 0;
    m_pen    = (nst == 1 || nst == 2) ? 1 : 0;
    m_over   = (nst == 4) ? 1 : 0;
    m_state = nst; m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
    m_sl = nsl; m_sr = nsr; m_serve = nserve;
  endtask

  task automatic compare_all();
    check("ball_x", int'(ball_x), m_bx);
    check("ball_y", int'(ball_y), m_by);
    check("draw_ball", int'(draw_ball), m_draw);
    check("score_l", int'(score_l), m_sl);
    check("score_r", int'(score_r), m_sr);
    check("state", int'(state), m_state);
    check("paddle_en", int'(paddle_en), m_pen);
    check("game_over", int'(game_over), m_over);
  endtask

  // One clock: drive at the falling edge, model on the rising edge, compare at the next fall.
  task automatic cycle(input bit r, input bit b);
    rst        = r;
    btn_start  = b;
    paddle_l_y = 6'(pad_pos(l_mode));
    paddle_r_y = 6'(pad_pos(r_mode));
    counter_x  = 6'(cx_set);
    counter_y  = 6'(cy_set);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_state(input int target, input int limit, input string name);
    int k = 0;
    while (int'(state) != target && k < limit) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    n_vec++;
    if (int'(state) != target) begin
      n_err++;
      $display("FAIL %s: state=%0d, expected %0d within %0d cycles", name, state, target, limit);
    end
  endtask

  initial begin
    int k, restarts, prev;

    tbl[0] = '{20, 17, 1, 1};
    tbl[1] = '{21, 17, 0, 1};
    tbl[2] = '{20, 18, 0, 1};
    tbl[3] = '{19, 16, 0, 1};
    tbl[4] = '{20, 17, 1, 1};
    tbl[5] = '{0, 0, 0, 1};
    tbl[6] = '{63, 63, 0, 1};
    tbl[7] = '{20, 17, 1, 2};

    @(negedge clk);
    cx_set = CX; cy_set = CY;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("rst_state", int'(state), 0);
    check("rst_ball_x", int'(ball_x), 20);
    check("rst_ball_y", int'(ball_y), 17);
    check("rst_draw", int'(draw_ball), 0);
    check("rst_paddle_en", int'(paddle_en), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_scores", int'(score_l) + int'(score_r), 0);

    // Start on the edge where the tick counter wraps so SERVE lasts exactly 2 ticks.
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("serve_entry_state", int'(state), 1);
    check("serve_paddle_en", int'(paddle_en), 1);
    for (int i = 0; i < 8; i++) begin
      cx_set = tbl[i].cx; cy_set = tbl[i].cy;
      cycle(1'b0, 1'b0);
      check("tbl_draw", int'(draw_ball), tbl[i].exp_draw);
      check("tbl_state", int'(state), tbl[i].exp_state);
      $display("vec %0d: cx=%0d cy=%0d draw=%0d state=%0d", i, tbl[i].cx, tbl[i].cy, draw_ball, state);
    end
    repeat (3) begin
      cycle(1'b0, 1'b0);
      check("pre_tick_ball_x", int'(ball_x), 20);
    end
    cycle(1'b0, 1'b0);
    check("first_tick_ball_x", int'(ball_x), 21);
    check("first_tick_ball_y", int'(ball_y), 18);
    $display("serve timing: play started, ball at (%0d,%0d)", ball_x, ball_y);

    // Rally with both paddles following the ball: walls, hits and corners only.
    l_mode = 0; r_mode = 0;
    for (int i = 0; i < 400; i++) begin
      cx_set = m_bx; cy_set = m_by;
      cycle(1'b0, 1'b0);
    end
    check("rally_no_score", int'(score_l) + int'(score_r), 0);
    $display("rally: ball at (%0d,%0d)", ball_x, ball_y);

    // Left paddle parked away: ball travels to column 0 and scores for the right.
    l_mode = 1;
    wait_state(3, 2000, "left_miss_point");
    check("left_miss_ball_x", int'(ball_x), 0);
    cycle(1'b0, 1'b0);
    check("after_point_state", int'(state), 1);
    check("after_point_ball_x", int'(ball_x), 20);
    check("after_point_ball_y", int'(ball_y), 17);
    check("after_point_score_r", int'(score_r), 1);
    wait_state(2, 100, "reserve_play");
    k = 0;
    while (ball_x == 6'd20 && k < 20) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    check("serve_toward_loser_x", int'(ball_x), 19);
    $display("left miss: score_r=%0d, served toward left", score_r);

    // Right paddle parked away: two right misses reach WIN_SCORE.
    l_mode = 0; r_mode = 1;
    wait_state(4, 4000, "game_over_state");
    check("over_score_l", int'(score_l), 2);
    check("over_game_over", int'(game_over), 1);
    check("over_paddle_en", int'(paddle_en), 0);
    cx_set = int'(ball_x); cy_set = int'(ball_y);
    repeat (3) begin
      cycle(1'b0, 1'b0);
      check("over_no_draw", int'(draw_ball), 0);
    end
    restarts = 0;
    prev = int'(state);
    repeat (30) begin
      cycle(1'b0, 1'b1);
      if (prev == 4 && int'(state) == 1) restarts++;
      if (prev != 4 && int'(state) == 4) restarts++;
      prev = int'(state);
    end
    check("restart_once", restarts, 1);
    check("restart_score_l", int'(score_l), 0);
    check("restart_score_r", int'(score_r), 0);
    $display("game over: restarted %0d time(s) with held button", restarts);

    // Reset in the middle of play with a nonzero score and the pixel on the ball.
    cycle(1'b0, 1'b0);
    k = 0;
    while (score_l != 4'd1 && k < 3000) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    check("midgame_score_l", int'(score_l), 1);
    wait_state(2, 100, "midgame_play");
    repeat (5) cycle(1'b0, 1'b0);
    cx_set = int'(ball_x); cy_set = int'(ball_y);
    cycle(1'b1, 1'b0);
    check("midrst_state", int'(state), 0);
    check("midrst_ball_x", int'(ball_x), 20);
    check("midrst_ball_y", int'(ball_y), 17);
    check("midrst_scores", int'(score_l) + int'(score_r), 0);
    check("midrst_draw", int'(draw_ball), 0);
    check("midrst_paddle_en", int'(paddle_en), 0);
    $display("mid-game reset: state=%0d ball=(%0d,%0d)", state, ball_x, ball_y);

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        l_mode = int'($urandom_range(0, 2));
        r_mode = int'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 1) begin
        cx_set = m_bx; cy_set = m_by;
      end else begin
        cx_set = int'($urandom_range(0, 63)); cy_set = int'($urandom_range(0, 63));
      end
      cycle($urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0);
    end
    $display("random: final state=%0d scores %0d:%0d", state, score_l, score_r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
